// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch request bus between the PC unit and instruction memory
//
// Purpose: carries one fetch request (address + valid) and the memory's ready.
// Signals:
//   req_valid  fetch request valid (PC unit -> memory)
//   req_ready  memory accepts the request (memory -> PC unit)
//   pc         request address, equal to the current PC (PC unit -> memory)
// Modports: master = PC unit side, slave = instruction-memory side.
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] pc;

  modport master (output req_valid, output pc, input req_ready);
  modport slave  (input req_valid, input pc, output req_ready);
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage program counter with pending redirect and misalignment fault
//
// Purpose: holds the PC, issues it to instruction memory over a valid/ready
// handshake, and advances it by 4 or redirects it to PCImm/AluOut. Redirects
// arriving while a request is waiting on req_ready are parked in a one-entry
// buffer and applied on acceptance. Misaligned jump targets enter FAULT.
// Optional feature macro: PC_TRAP_EN (adds trap_req, trap_vec, epc).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   bus (master)    req_valid / req_ready / pc fetch request
//   jump, jumpSel   redirect request and target select
//   PCImm, AluOut   candidate redirect targets
//   stall           suppresses issuing a new fetch request
//   fault_clr       leave FAULT, restart at RESET_VECTOR
//   pc4             pc + 4 (combinational, wrapping)
//   fault           high while in FAULT
//   fault_addr      misaligned target that caused the fault
//   trap_req, trap_vec, epc   (PC_TRAP_EN only) trap entry and saved PC
module fetch_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus,
  input  logic            jump,
  input  logic [1:0]      jumpSel,
  input  logic [XLEN-1:0] PCImm,
  input  logic [XLEN-1:0] AluOut,
  input  logic            stall,
  input  logic            fault_clr,
  output logic [XLEN-1:0] pc4,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
`ifdef PC_TRAP_EN
  ,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] epc
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  // Number of low target bits that must be zero for a legal target.
  localparam int ALIGN_W = (IALIGN == 2) ? 1 : 2;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            held_q, held_d;
  logic            req_valid;
  logic            stalled;
  logic [XLEN-1:0] target;
  logic            misaligned;
`ifdef PC_TRAP_EN
  logic [XLEN-1:0] epc_q, epc_d;
`endif

  assign pc4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  always_comb begin
    target = pc4;
    case (jumpSel)
      2'b01:   target = PCImm;
      2'b10:   target = AluOut;
      default: target = pc4;
    endcase
  end

  assign misaligned = (target[ALIGN_W-1:0] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      fault_addr_q  <= '0;
      held_q        <= 1'b0;
`ifdef PC_TRAP_EN
      epc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fault_addr_q  <= fault_addr_d;
      held_q        <= held_d;
`ifdef PC_TRAP_EN
      epc_q         <= epc_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    fault_addr_d  = fault_addr_q;
    held_d        = 1'b0;
    req_valid     = 1'b0;
    stalled       = 1'b0;
`ifdef PC_TRAP_EN
    epc_d         = epc_q;
`endif
    case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        // Once offered, a request stays up until accepted, regardless of stall.
        req_valid = held_q | ~stall;
        stalled   = req_valid & ~bus.req_ready;
        held_d    = stalled;
`ifdef PC_TRAP_EN
        if (trap_req) begin
          epc_d = pc_q;
          if (stalled) begin
            pend_valid_d  = 1'b1;
            pend_target_d = trap_vec;
          end else begin
            pc_d         = trap_vec;
            pend_valid_d = 1'b0;
          end
        end else
`endif
        if (jump && misaligned) begin
          state_d      = FAULT;
          fault_addr_d = target;
          pend_valid_d = 1'b0;
        end else if (jump && stalled) begin
          // The in-flight address must not change; park the newest target.
          pend_valid_d  = 1'b1;
          pend_target_d = target;
        end else if (jump) begin
          pc_d         = target;
          pend_valid_d = 1'b0;
        end else if (req_valid && bus.req_ready) begin
          pc_d         = pend_valid_q ? pend_target_q : pc4;
          pend_valid_d = 1'b0;
        end
      end

      FAULT: begin
`ifdef PC_TRAP_EN
        if (trap_req) begin
          epc_d        = fault_addr_q;
          pc_d         = trap_vec;
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end else
`endif
        if (fault_clr) begin
          pc_d         = RESET_VECTOR;
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  assign bus.req_valid = req_valid;
  assign bus.pc        = pc_q;
  assign fault         = (state_q == FAULT);
  assign fault_addr    = fault_addr_q;
`ifdef PC_TRAP_EN
  assign epc           = epc_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump = 1'b0;
  logic [1:0]  jumpSel = 2'b00;
  logic [31:0] PCImm = '0;
  logic [31:0] AluOut = '0;
  logic        stall = 1'b0;
  logic        fault_clr = 1'b0;
  logic [31:0] pc4;
  logic        fault;
  logic [31:0] fault_addr;
`ifdef PC_TRAP_EN
  logic        trap_req = 1'b0;
  logic [31:0] trap_vec = '0;
  logic [31:0] epc;
`endif

  int checks = 0;
  int errors = 0;

  fetch_pc_unit_if #(.XLEN(32)) bus ();

  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .jump       (jump),
    .jumpSel    (jumpSel),
    .PCImm      (PCImm),
    .AluOut     (AluOut),
    .stall      (stall),
    .fault_clr  (fault_clr),
    .pc4        (pc4),
    .fault      (fault),
    .fault_addr (fault_addr)
`ifdef PC_TRAP_EN
    ,
    .trap_req   (trap_req),
    .trap_vec   (trap_vec),
    .epc        (epc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        stall;
    logic        rdy;
    logic        clr;
    logic [31:0] e_pc;
    logic        e_rv;
    logic        e_fault;
    logic [31:0] e_faddr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(logic j, logic [1:0] s, logic [31:0] im, logic [31:0] al,
                              logic st, logic rd, logic cl,
                              logic [31:0] epc_v, logic erv, logic ef, logic [31:0] efa);
    vec_t v;
    v.jump = j; v.sel = s; v.imm = im; v.alu = al; v.stall = st; v.rdy = rd; v.clr = cl;
    v.e_pc = epc_v; v.e_rv = erv; v.e_fault = ef; v.e_faddr = efa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // Each row is one cycle: inputs applied, outputs observed before the next edge.
    vecs[0]  = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0);
    vecs[1]  = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h0,   1, 0, 32'h0);
    vecs[2]  = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h4,   1, 0, 32'h0);
    vecs[3]  = mk(0, 2'd0, 0, 0, 1, 1, 0, 32'h8,   0, 0, 32'h0);
    vecs[4]  = mk(0, 2'd0, 0, 0, 1, 1, 0, 32'h8,   0, 0, 32'h0);
    vecs[5]  = mk(0, 2'd0, 0, 0, 1, 1, 0, 32'h8,   0, 0, 32'h0);
    vecs[6]  = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h8,   1, 0, 32'h0);
    vecs[7]  = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'hC,   1, 0, 32'h0);
    vecs[8]  = mk(1, 2'd1, 32'h100, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0);
    vecs[9]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 32'h0);
    vecs[10] = mk(0, 2'd0, 0, 0, 1, 1, 0, 32'h10,  1, 0, 32'h0);
    vecs[11] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h100, 1, 0, 32'h0);
    vecs[12] = mk(1, 2'd1, 32'h200, 0, 0, 0, 0, 32'h104, 1, 0, 32'h0);
    vecs[13] = mk(1, 2'd2, 0, 32'h300, 0, 0, 0, 32'h104, 1, 0, 32'h0);
    vecs[14] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h104, 1, 0, 32'h0);
    vecs[15] = mk(1, 2'd1, 32'h40, 0, 0, 1, 0, 32'h300, 1, 0, 32'h0);
    vecs[16] = mk(1, 2'd0, 0, 0, 0, 1, 0, 32'h40,  1, 0, 32'h0);
    vecs[17] = mk(1, 2'd3, 0, 0, 0, 1, 0, 32'h44,  1, 0, 32'h0);
    vecs[18] = mk(1, 2'd2, 0, 32'h102, 0, 1, 0, 32'h48, 1, 0, 32'h0);
    vecs[19] = mk(1, 2'd1, 32'h500, 0, 0, 1, 0, 32'h48, 0, 1, 32'h102);
    vecs[20] = mk(0, 2'd0, 0, 0, 0, 1, 1, 32'h48,  0, 1, 32'h102);
    vecs[21] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h0,   1, 0, 32'h102);
    vecs[22] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h4,   1, 0, 32'h102);
    vecs[23] = mk(1, 2'd1, 32'h600, 0, 1, 1, 0, 32'h8, 0, 0, 32'h102);
    vecs[24] = mk(1, 2'd2, 0, 32'hFFFF_FFFC, 0, 1, 0, 32'h600, 1, 0, 32'h102);
    vecs[25] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 0, 32'h102);
    vecs[26] = mk(0, 2'd0, 0, 0, 0, 1, 0, 32'h0,   1, 0, 32'h102);

    bus.req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_pc4", pc4, 32'h4);
    chk("reset_req_valid", {31'b0, bus.req_valid}, 32'h0);
    chk("reset_fault", {31'b0, fault}, 32'h0);
    chk("reset_fault_addr", fault_addr, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      jump = vecs[i].jump; jumpSel = vecs[i].sel; PCImm = vecs[i].imm; AluOut = vecs[i].alu;
      stall = vecs[i].stall; bus.req_ready = vecs[i].rdy; fault_clr = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].e_pc);
      chk($sformatf("v%0d_pc4", i), pc4, vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d_req_valid", i), {31'b0, bus.req_valid}, {31'b0, vecs[i].e_rv});
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].e_fault});
      chk($sformatf("v%0d_fault_addr", i), fault_addr, vecs[i].e_faddr);
      @(negedge clk);
    end

    // Reset mid-operation discards a pending redirect and clears fault_addr.
    jump = 1'b1; jumpSel = 2'd1; PCImm = 32'h700; stall = 1'b0; bus.req_ready = 1'b0; fault_clr = 1'b0;
    #1;
    chk("pend_pc_before", bus.pc, 32'h4);
    @(negedge clk);
    jump = 1'b0;
    #1;
    chk("pend_pc_held", bus.pc, 32'h4);
    rst = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, 32'h0);
    chk("async_rst_req_valid", {31'b0, bus.req_valid}, 32'h0);
    chk("async_rst_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1; bus.req_ready = 1'b1;
    #1;
    chk("reboot_req_valid", {31'b0, bus.req_valid}, 32'h0);
    @(negedge clk); #1;
    chk("reboot_pc0", bus.pc, 32'h0);
    chk("reboot_req_valid1", {31'b0, bus.req_valid}, 32'h1);
    @(negedge clk); #1;
    chk("pend_discarded_pc", bus.pc, 32'h4);

    // Fault then reset: fault state dropped immediately.
    jump = 1'b1; jumpSel = 2'd2; AluOut = 32'h3;
    @(negedge clk);
    jump = 1'b0;
    #1;
    chk("fault_set", {31'b0, fault}, 32'h1);
    chk("fault_addr_3", fault_addr, 32'h3);
    chk("fault_req_valid", {31'b0, bus.req_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_clears_fault", {31'b0, fault}, 32'h0);
    chk("rst_clears_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

`ifdef PC_TRAP_EN
    @(negedge clk);
    jump = 1'b1; jumpSel = 2'd1; PCImm = 32'h40;
    @(negedge clk);
    PCImm = 32'h200; trap_req = 1'b1; trap_vec = 32'h80;
    #1;
    chk("trap_pc_before", bus.pc, 32'h40);
    @(negedge clk);
    jump = 1'b0; trap_req = 1'b0;
    #1;
    chk("trap_pc", bus.pc, 32'h80);
    chk("trap_epc", epc, 32'h40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
